// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - round-robin select sequencer and sampler for a 4:1 single-bit mux
//
// Purpose:
//   Walks the downstream 4:1 mux select across the enabled channels, holds each
//   select for DWELL cycles, captures the mux output in the last dwell cycle and
//   reports it per channel, plus a 4-bit snapshot once each sweep completes.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           in   scan enable (level)
//   ch_mask[3:0] in   channel enable mask, latched at sweep start
//   mux_y        in   downstream mux output
//   sel[1:0]     out  mux select (registered)
//   busy         out  sweep in progress
//   sample_valid out  one-cycle pulse, new sample on sample_ch/sample_bit
//   sample_ch    out  channel of the current sample
//   sample_bit   out  captured mux_y value
//   scan_done    out  one-cycle pulse at sweep completion
//   snap[3:0]    out  last sweep's per-channel samples (masked channels 0)
module mux_sel_scanner #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] ch_mask,
  input  logic       mux_y,
  output logic [1:0] sel,
  output logic       busy,
  output logic       sample_valid,
  output logic [1:0] sample_ch,
  output logic       sample_bit,
  output logic       scan_done,
  output logic [3:0] snap
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_t        state;
  logic [CW-1:0] dwell_cnt;
  logic [3:0]    mask_q;
  logic [3:0]    shadow;
  logic [3:0]    shadow_cap;
  logic [3:0]    above;

  // Index of the lowest set bit; callers guarantee a non-zero mask.
  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    if (m[3]) r = 2'd3;
    if (m[2]) r = 2'd2;
    if (m[1]) r = 2'd1;
    if (m[0]) r = 2'd0;
    return r;
  endfunction

  // Enabled channels strictly above the current select.
  assign above = mask_q & (4'b1110 << sel);

  // Shadow snapshot including the bit being captured this cycle, so the
  // final channel of a sweep lands in snap on the same edge.
  always_comb begin
    shadow_cap      = shadow;
    shadow_cap[sel] = mux_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= 2'd0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= 2'd0;
      sample_bit   <= 1'b0;
      scan_done    <= 1'b0;
      snap         <= 4'd0;
      dwell_cnt    <= '0;
      mask_q       <= 4'd0;
      shadow       <= 4'd0;
    end else begin
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (en && (ch_mask != 4'd0)) begin
            mask_q    <= ch_mask;
            shadow    <= 4'd0;
            sel       <= lowest(ch_mask);
            dwell_cnt <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (dwell_cnt == LAST) begin
            sample_bit   <= mux_y;
            sample_ch    <= sel;
            sample_valid <= 1'b1;
            shadow       <= shadow_cap;
            if (above != 4'd0) begin
              sel       <= lowest(above);
              dwell_cnt <= '0;
            end else begin
              snap      <= shadow_cap;
              scan_done <= 1'b1;
              if (en && (ch_mask != 4'd0)) begin
                // Back-to-back sweep: restart with no idle gap.
                mask_q    <= ch_mask;
                shadow    <= 4'd0;
                sel       <= lowest(ch_mask);
                dwell_cnt <= '0;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb/tb_mux_sel_scanner.sv - directed self-checking bench for mux_sel_scanner
module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // DWELL=4 instance
  logic       en = 1'b0;
  logic [3:0] ch_mask = 4'd0;
  logic [3:0] muxin = 4'd0;
  logic       mux_y;
  logic [1:0] sel;
  logic       busy, sample_valid, sample_bit, scan_done;
  logic [1:0] sample_ch;
  logic [3:0] snap;

  // DWELL=2 instance
  logic       en2 = 1'b0;
  logic [3:0] ch_mask2 = 4'd0;
  logic [3:0] muxin2 = 4'd0;
  logic       mux_y2;
  logic [1:0] sel2;
  logic       busy2, sample_valid2, sample_bit2, scan_done2;
  logic [1:0] sample_ch2;
  logic [3:0] snap2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux: bit i of muxin is input a..d.
  assign mux_y  = muxin[sel];
  assign mux_y2 = muxin2[sel2];

  mux_sel_scanner #(.DWELL(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .mux_y(mux_y),
    .sel(sel), .busy(busy), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_bit(sample_bit), .scan_done(scan_done), .snap(snap)
  );

  mux_sel_scanner #(.DWELL(2), .CW(8)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .ch_mask(ch_mask2), .mux_y(mux_y2),
    .sel(sel2), .busy(busy2), .sample_valid(sample_valid2), .sample_ch(sample_ch2),
    .sample_bit(sample_bit2), .scan_done(scan_done2), .snap(snap2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({sel, busy, sample_valid, sample_ch, sample_bit, scan_done, snap} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got sel=%0d busy=%0b sv=%0b ch=%0d bit=%0b sd=%0b snap=%b want all 0",
               sel, busy, sample_valid, sample_ch, sample_bit, scan_done, snap);
    end
    rst = 1'b0;
  endtask

  // Test 1: full sweep, en dropped after start.
  task automatic test_full_sweep();
    muxin   = 4'b1010;
    ch_mask = 4'b1111;
    en      = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (sel !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_start got sel=%0d busy=%0b want sel=0 busy=1", sel, busy);
    end
    for (int c = 1; c <= 16; c++) begin
      logic [1:0] esel;
      tick();
      esel = (c < 16) ? 2'(c / 4) : 2'd3;
      checks++;
      if (sel !== esel) begin
        errors++;
        $display("FAIL t1_sel c=%0d got %0d want %0d", c, sel, esel);
      end
      checks++;
      if (sample_valid !== (c % 4 == 0) || scan_done !== (c == 16)) begin
        errors++;
        $display("FAIL t1_pulses c=%0d got sv=%0b sd=%0b want sv=%0b sd=%0b",
                 c, sample_valid, scan_done, (c % 4 == 0), (c == 16));
      end
      if (c % 4 == 0) begin
        checks++;
        if (sample_ch !== 2'(c / 4 - 1) || sample_bit !== muxin[c / 4 - 1]) begin
          errors++;
          $display("FAIL t1_sample c=%0d got ch=%0d bit=%0b want ch=%0d bit=%0b",
                   c, sample_ch, sample_bit, c / 4 - 1, muxin[c / 4 - 1]);
        end
      end
    end
    checks++;
    if (snap !== 4'b1010 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_end got snap=%b busy=%0b want snap=1010 busy=0", snap, busy);
    end
  endtask

  // Test 2: sparse mask, continuous back-to-back sweeps.
  task automatic test_back_to_back();
    ch_mask = 4'b1010;
    en      = 1'b1;
    tick();
    checks++;
    if (sel !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t2_start got sel=%0d busy=%0b want sel=1 busy=1", sel, busy);
    end
    for (int c = 1; c <= 24; c++) begin
      logic [1:0] esel;
      tick();
      if (c == 17) en = 1'b0;
      esel = (c == 24) ? 2'd3 : (((c / 4) % 2 == 0) ? 2'd1 : 2'd3);
      checks++;
      if (sel !== esel || busy !== (c < 24)) begin
        errors++;
        $display("FAIL t2_sel c=%0d got sel=%0d busy=%0b want sel=%0d busy=%0b",
                 c, sel, busy, esel, (c < 24));
      end
      checks++;
      if (scan_done !== (c % 8 == 0) || sample_valid !== (c % 4 == 0)) begin
        errors++;
        $display("FAIL t2_pulses c=%0d got sd=%0b sv=%0b want sd=%0b sv=%0b",
                 c, scan_done, sample_valid, (c % 8 == 0), (c % 4 == 0));
      end
      if (c % 8 == 0) begin
        checks++;
        if (snap !== 4'b1010) begin
          errors++;
          $display("FAIL t2_snap c=%0d got %b want 1010", c, snap);
        end
      end
    end
  endtask

  // Test 3: empty mask never starts a sweep.
  task automatic test_empty_mask();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ch_mask = 4'b0000;
    en      = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || sample_valid !== 1'b0 || scan_done !== 1'b0 || sel !== 2'd0) begin
        errors++;
        $display("FAIL t3_idle c=%0d got busy=%0b sv=%0b sd=%0b sel=%0d want 0 0 0 0",
                 c, busy, sample_valid, scan_done, sel);
      end
    end
    en = 1'b0;
  endtask

  // Test 4: en dropped and mask changed mid-sweep.
  task automatic test_mid_sweep_change();
    muxin   = 4'b0110;
    ch_mask = 4'b1111;
    en      = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 6) begin
        en      = 1'b0;
        ch_mask = 4'b0001;
      end
      if (c % 4 == 0) begin
        checks++;
        if (sample_valid !== 1'b1 || sample_ch !== 2'(c / 4 - 1)) begin
          errors++;
          $display("FAIL t4_sample c=%0d got sv=%0b ch=%0d want sv=1 ch=%0d",
                   c, sample_valid, sample_ch, c / 4 - 1);
        end
      end
    end
    checks++;
    if (scan_done !== 1'b1 || snap !== 4'b0110 || sel !== 2'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_end got sd=%0b snap=%b sel=%0d busy=%0b want sd=1 snap=0110 sel=3 busy=0",
               scan_done, snap, sel, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || sel !== 2'd3 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL t4_idle got busy=%0b sel=%0d sd=%0b want 0 3 0", busy, sel, scan_done);
    end
  endtask

  // Test 5: asynchronous reset mid-sweep, then restart.
  task automatic test_async_reset();
    ch_mask = 4'b1111;
    en      = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sel, busy, sample_valid, sample_ch, sample_bit, scan_done, snap} !== 12'd0) begin
      errors++;
      $display("FAIL t5_async got sel=%0d busy=%0b sv=%0b ch=%0d bit=%0b sd=%0b snap=%b want all 0",
               sel, busy, sample_valid, sample_ch, sample_bit, scan_done, snap);
    end
    #1 rst = 1'b0;
    ch_mask = 4'b1100;
    tick();
    checks++;
    if (sel !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t5_restart got sel=%0d busy=%0b want sel=2 busy=1", sel, busy);
    end
    en = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    checks++;
    if (busy !== 1'b0 || snap !== 4'b0100) begin
      errors++;
      $display("FAIL t5_done got busy=%0b snap=%b want busy=0 snap=0100", busy, snap);
    end
  endtask

  // Test 6: minimum dwell, single channel.
  task automatic test_dwell2_single();
    muxin2   = 4'b0100;
    ch_mask2 = 4'b0100;
    en2      = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (sel2 !== 2'd2 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL t6_sel c=%0d got sel=%0d busy=%0b want sel=2 busy=1", c, sel2, busy2);
      end
      checks++;
      if (sample_valid2 !== (c % 2 == 0) || scan_done2 !== (c % 2 == 0)) begin
        errors++;
        $display("FAIL t6_pulses c=%0d got sv=%0b sd=%0b want %0b", c, sample_valid2, scan_done2, (c % 2 == 0));
      end
      if (c % 2 == 0) begin
        checks++;
        if (snap2 !== 4'b0100 || sample_bit2 !== 1'b1 || sample_ch2 !== 2'd2) begin
          errors++;
          $display("FAIL t6_sample c=%0d got snap=%b bit=%0b ch=%0d want 0100 1 2",
                   c, snap2, sample_bit2, sample_ch2);
        end
      end
    end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_back_to_back();
    test_empty_mask();
    test_mid_sweep_change();
    test_async_reset();
    test_dwell2_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
